// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, program bases, branch offset table.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int OFF_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [PC_W_DEF-1:0] BASE0 = 10'h000;
  localparam logic [PC_W_DEF-1:0] BASE1 = 10'h080;
  localparam logic [PC_W_DEF-1:0] BASE2 = 10'h100;
  localparam logic [PC_W_DEF-1:0] BASE3 = 10'h200;

  // Halt opcode as seen by the control decoder; Ack is its decoded form.
  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  // Signed relative offsets, two's complement:
  // +1 +2 +3 -4 +8 -8 +16 -16 +32 -32 +64 -64 +127 -128 +5 -5
  localparam logic signed [OFF_W_DEF-1:0] OFF_LUT [16] = '{
    8'h01, 8'h02, 8'h03, 8'hFC, 8'h08, 8'hF8, 8'h10, 8'hF0,
    8'h20, 8'hE0, 8'h40, 8'hC0, 8'h7F, 8'h80, 8'h05, 8'hFB
  };

  function automatic logic [PC_W_DEF-1:0] base_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    return BASE0;
      2'd1:    return BASE1;
      2'd2:    return BASE2;
      default: return BASE3;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: start/done handshake, branch controls in, ROM address and status out.
// Latency: n/a (wires only).
// Backpressure: none; master drives controls, slave (sequencer) drives address/status.
interface fetch_sequencer_if #(parameter int PC_W = 10);
  logic            Start;
  logic [1:0]      ProgSel;
  logic            BranchEn;
  logic            BrNe;
  logic            Zero;
  logic [3:0]      TargIdx;
  logic            Ack;
  logic [PC_W-1:0] ProgCtr;
  logic            Running;
  logic            Done;
  logic [15:0]     CycleCnt;
  logic            Fault;

  modport master (
    output Start, ProgSel, BranchEn, BrNe, Zero, TargIdx, Ack,
    input  ProgCtr, Running, Done, CycleCnt, Fault
  );

  modport slave (
    input  Start, ProgSel, BranchEn, BrNe, Zero, TargIdx, Ack,
    output ProgCtr, Running, Done, CycleCnt, Fault
  );
endinterface

// File: rtl/fetch_sequencer_branch_offset_lut.sv
// Branch offset lookup: TargIdx -> signed relative offset (regenerated per program).
// Latency: combinational.
// Backpressure: none.
// Ports: TargIdx (4b index), Offset (signed OFF_W).
module branch_offset_lut
  import fetch_sequencer_pkg::*;
#(
  parameter int OFF_W = 8
) (
  input  logic [3:0]              TargIdx,
  output logic signed [OFF_W-1:0] Offset
);

  assign Offset = OFF_W'(OFF_LUT[TargIdx]);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter sequencer: IDLE/RUN/DONE with start/done handshake and LUT branches.
// Latency: one cycle per PC update; branches resolve in one cycle, no delay slots.
// Backpressure: none; Start=1 holds/aborts, Ack halts.
// Ports: Clk, Reset (sync, active-high), bus (fetch_sequencer_if.slave).
// Option: PC_BOUND_CHECK_EN enables PC bound checking (Fault); otherwise the PC wraps.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int OFF_W      = 8,
  parameter int PROG_DEPTH = 1024
) (
  input logic              Clk,
  input logic              Reset,
  fetch_sequencer_if.slave bus
);

  fetch_state_t            state_q, state_nxt;
  logic                    start_q;
  logic [PC_W-1:0]         pc_q, pc_nxt, base_pc;
  logic [15:0]             cnt_q, cnt_nxt;
  logic                    done_q, done_nxt, running_q;
  logic signed [OFF_W-1:0] br_off;
  logic                    taken;
  logic [PC_W+1:0]         step, sum;

  branch_offset_lut #(.OFF_W(OFF_W)) u_lut (
    .TargIdx (bus.TargIdx),
    .Offset  (br_off)
  );

  assign base_pc = PC_W'(base_addr(bus.ProgSel));
  assign taken   = bus.BranchEn & (bus.BrNe ? ~bus.Zero : bus.Zero);

  // Two guard bits above the PC: bit PC_W catches carry-out, bit PC_W+1 a borrow.
  assign step = taken ? {{(PC_W+2-OFF_W){br_off[OFF_W-1]}}, br_off} : (PC_W+2)'(1);
  assign sum  = {2'b00, pc_q} + step;

`ifdef PC_BOUND_CHECK_EN
  logic fault_q, fault_nxt, oob;
  assign oob = sum[PC_W+1] | (sum >= (PC_W+2)'(PROG_DEPTH));
`else
  localparam int unused_depth = PROG_DEPTH;
  logic [1:0] unused_sum_hi;
  assign unused_sum_hi = sum[PC_W+1:PC_W];
`endif

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    done_nxt  = done_q;
`ifdef PC_BOUND_CHECK_EN
    fault_nxt = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          pc_nxt   = base_pc;
          cnt_nxt  = '0;
          done_nxt = 1'b0;
`ifdef PC_BOUND_CHECK_EN
          fault_nxt = 1'b0;
`endif
        end else if (start_q) begin
          // Falling edge of Start: launch at the base already loaded.
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.Start) begin
          // Abort reloads the base so a one-cycle Start pulse restarts cleanly.
          state_nxt = IDLE;
          pc_nxt    = base_pc;
          cnt_nxt   = '0;
          done_nxt  = 1'b0;
`ifdef PC_BOUND_CHECK_EN
          fault_nxt = 1'b0;
`endif
        end else if (bus.Ack) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          cnt_nxt   = sat_inc16(cnt_q);
        end else begin
`ifdef PC_BOUND_CHECK_EN
          if (oob) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt  = sum[PC_W-1:0];
            cnt_nxt = sat_inc16(cnt_q);
          end
`else
          pc_nxt  = sum[PC_W-1:0];
          cnt_nxt = sat_inc16(cnt_q);
`endif
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_nxt = IDLE;
          pc_nxt    = base_pc;
          cnt_nxt   = '0;
          done_nxt  = 1'b0;
`ifdef PC_BOUND_CHECK_EN
          fault_nxt = 1'b0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      pc_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      start_q   <= bus.Start;
      pc_q      <= pc_nxt;
      cnt_q     <= cnt_nxt;
      done_q    <= done_nxt;
      running_q <= (state_nxt == RUN);
    end
  end

`ifdef PC_BOUND_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Reset) fault_q <= 1'b0;
    else       fault_q <= fault_nxt;
  end
  assign bus.Fault = fault_q;
`else
  assign bus.Fault = 1'b0;
`endif

  assign bus.ProgCtr  = pc_q;
  assign bus.Running  = running_q;
  assign bus.Done     = done_q;
  assign bus.CycleCnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random stimulus against a behavioural model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_fetch_sequencer;

  logic Clk = 1'b0;
  logic Reset;

  fetch_sequencer_if #(.PC_W(10)) bus ();

  fetch_sequencer #(.PC_W(10), .OFF_W(8), .PROG_DEPTH(1024)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a mode number, integer PC and counters.
  int  m_mode;   // 0 idle, 1 running, 2 finished
  int  m_pc;
  int  m_cnt;
  bit  m_done;
  bit  m_prev_start;
  int  lut  [16] = '{1, 2, 3, -4, 8, -8, 16, -16, 32, -32, 64, -64, 127, -128, 5, -5};
  int  base [4]  = '{'h000, 'h080, 'h100, 'h200};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_tick(input bit rs, st, input int sel, input bit be, bne, z,
                            input int ti, input bit ak);
    bit fall;
    if (rs) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_done = 0; m_prev_start = 0;
      return;
    end
    fall = m_prev_start && !st;
    m_prev_start = st;
    if (m_mode == 0) begin
      if (st) begin m_pc = base[sel]; m_cnt = 0; m_done = 0; end
      else if (fall) m_mode = 1;
    end else if (m_mode == 1) begin
      if (st) begin
        m_mode = 0; m_pc = base[sel]; m_cnt = 0; m_done = 0;
      end else if (ak) begin
        m_mode = 2; m_done = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        if (be && (bne ? !z : z)) m_pc = (m_pc + lut[ti]) & 1023;
        else                      m_pc = (m_pc + 1) & 1023;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      if (st) begin m_mode = 0; m_pc = base[sel]; m_cnt = 0; m_done = 0; end
    end
  endtask

  task automatic compare_all();
    chk("ProgCtr",  32'(bus.ProgCtr),  32'(m_pc));
    chk("Running",  32'(bus.Running),  32'(m_mode == 1));
    chk("Done",     32'(bus.Done),     32'(m_done));
    chk("CycleCnt", 32'(bus.CycleCnt), 32'(m_cnt));
    chk("Fault",    32'(bus.Fault),    32'd0);
  endtask

  task automatic step(input bit rs, st, input int sel, input bit be, bne, z,
                      input int ti, input bit ak);
    Reset        = rs;
    bus.Start    = st;
    bus.ProgSel  = 2'(sel);
    bus.BranchEn = be;
    bus.BrNe     = bne;
    bus.Zero     = z;
    bus.TargIdx  = 4'(ti);
    bus.Ack      = ak;
    model_tick(rs, st, sel, be, bne, z, ti, ak);
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 1100 && m_pc != target; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("run_to", 32'(bus.ProgCtr), 32'(target));
  endtask

  initial begin
    bit st;
    int c0;

    // Reset values
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc",  32'(bus.ProgCtr),  32'h0);
    chk("rst_run", 32'(bus.Running),  32'h0);
    chk("rst_cnt", 32'(bus.CycleCnt), 32'h0);
    // No falling edge after reset: stays idle
    run(3);
    chk("idle_hold", 32'(bus.Running), 32'h0);

    // Launch program 1, straight-line fetch
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("base1", 32'(bus.ProgCtr), 32'h080);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("launch_run", 32'(bus.Running), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("seq_pc", 32'(bus.ProgCtr), 32'(32'h080 + i));
      run(1);
    end
    chk("seq_cnt", 32'(bus.CycleCnt), 32'd5);

    // Branches at 090 with LUT[3] = -4
    run_to('h090);
    step(0, 0, 0, 1, 0, 1, 3, 0);
    chk("beq_taken", 32'(bus.ProgCtr), 32'h08C);
    run_to('h090);
    step(0, 0, 0, 1, 0, 0, 3, 0);
    chk("beq_not", 32'(bus.ProgCtr), 32'h091);
    step(0, 0, 0, 1, 1, 0, 3, 0);
    chk("bne_taken", 32'(bus.ProgCtr), 32'h08D);
    step(0, 0, 0, 1, 1, 1, 3, 0);
    chk("bne_not", 32'(bus.ProgCtr), 32'h08E);

    // Ack wins over a taken branch at 0A0
    run_to('h0A0);
    c0 = m_cnt;
    step(0, 0, 0, 1, 0, 1, 3, 1);
    chk("ack_pc",   32'(bus.ProgCtr),  32'h0A0);
    chk("ack_done", 32'(bus.Done),     32'h1);
    chk("ack_cnt",  32'(bus.CycleCnt), 32'(c0 + 1));
    run(2);
    chk("done_hold", 32'(bus.ProgCtr), 32'h0A0);
    step(0, 1, 2, 0, 0, 0, 0, 0);
    chk("restart_pc",   32'(bus.ProgCtr), 32'h100);
    chk("restart_done", 32'(bus.Done),    32'h0);

    // One-cycle Start pulse mid-run
    step(0, 0, 2, 0, 0, 0, 0, 0);
    run(3);
    step(0, 1, 2, 0, 0, 0, 0, 0);
    chk("abort_pc",  32'(bus.ProgCtr), 32'h100);
    chk("abort_run", 32'(bus.Running), 32'h0);
    step(0, 0, 2, 0, 0, 0, 0, 0);
    chk("resume_run", 32'(bus.Running), 32'h1);
    run(1);
    chk("resume_pc", 32'(bus.ProgCtr), 32'h101);

    // Wrap at the top of the ROM
    step(0, 1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 3, 0, 0, 0, 0, 0);
    run_to('h3FF);
    run(1);
    chk("wrap_pc", 32'(bus.ProgCtr), 32'h000);

    // Reset mid-run
    run(4);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_pc",   32'(bus.ProgCtr),  32'h0);
    chk("mid_rst_run",  32'(bus.Running),  32'h0);
    chk("mid_rst_cnt",  32'(bus.CycleCnt), 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    st = 0;
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, 99) < (st ? 70 : 4));
      step(($urandom_range(0, 299) == 0), st, $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
           $urandom_range(0, 15), ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
